// File: rtl/sp_dram_arbiter_if.sv
// Bundle of both requester ports and the DRAM-wrapper port shared by the arbiter.
// The slave modport is the arbiter's view; master is the requesters plus memory.
interface sp_dram_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MASK_WIDTH = 16
);
  logic                  p0_req;
  logic                  p0_wr;
  logic [ADDR_WIDTH-1:0] p0_addr;
  logic [DATA_WIDTH-1:0] p0_wdata;
  logic [MASK_WIDTH-1:0] p0_mask;
  logic                  p0_ack;
  logic [DATA_WIDTH-1:0] p0_rdata;
  logic                  p0_rvalid;

  logic                  p1_req;
  logic                  p1_wr;
  logic [ADDR_WIDTH-1:0] p1_addr;
  logic [DATA_WIDTH-1:0] p1_wdata;
  logic [MASK_WIDTH-1:0] p1_mask;
  logic                  p1_ack;
  logic [DATA_WIDTH-1:0] p1_rdata;
  logic                  p1_rvalid;

  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_din;
  logic [MASK_WIDTH-1:0] mem_mask;
  logic                  mem_we;
  logic                  mem_re;
  logic [DATA_WIDTH-1:0] mem_dout;
  logic                  mem_ready;

  modport master (
    output p0_req, p0_wr, p0_addr, p0_wdata, p0_mask,
    input  p0_ack, p0_rdata, p0_rvalid,
    output p1_req, p1_wr, p1_addr, p1_wdata, p1_mask,
    input  p1_ack, p1_rdata, p1_rvalid,
    input  mem_addr, mem_din, mem_mask, mem_we, mem_re,
    output mem_dout, mem_ready
  );

  modport slave (
    input  p0_req, p0_wr, p0_addr, p0_wdata, p0_mask,
    output p0_ack, p0_rdata, p0_rvalid,
    input  p1_req, p1_wr, p1_addr, p1_wdata, p1_mask,
    output p1_ack, p1_rdata, p1_rvalid,
    output mem_addr, mem_din, mem_mask, mem_we, mem_re,
    input  mem_dout, mem_ready
  );
endinterface

// File: rtl/sp_dram_arbiter.sv
// Two-port round-robin arbiter onto a single DRAM command port.
// One command outstanding at a time; reads wait for mem_ready before returning data.
module sp_dram_arbiter #(
  parameter int unsigned ADDR_WIDTH = 26,
  parameter int unsigned DATA_WIDTH = 128,
  parameter int unsigned MASK_WIDTH = 16
) (
  input logic              clk,
  input logic              rst_n,
  sp_dram_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, RWAIT} state_t;

  typedef struct packed {
    logic                  wr;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [MASK_WIDTH-1:0] mask;
  } cmd_t;

  state_t                state;
  cmd_t                  cmd;
  logic                  owner;
  logic                  last_grant;
  logic                  rwait_first;
  logic                  mem_we;
  logic                  mem_re;
  logic                  p0_ack;
  logic                  p1_ack;
  logic                  p0_rvalid;
  logic                  p1_rvalid;
  logic [DATA_WIDTH-1:0] p0_rdata;
  logic [DATA_WIDTH-1:0] p1_rdata;

  logic                  grant_c;
  cmd_t                  p0_cmd_c;
  cmd_t                  p1_cmd_c;
  cmd_t                  win_cmd_c;

  assign p0_cmd_c  = {bus.p0_wr, bus.p0_addr, bus.p0_wdata, bus.p0_mask};
  assign p1_cmd_c  = {bus.p1_wr, bus.p1_addr, bus.p1_wdata, bus.p1_mask};
  assign win_cmd_c = grant_c ? p1_cmd_c : p0_cmd_c;

  // Round-robin pick: on contention the port not granted last wins.
  always_comb begin
    grant_c = 1'b0;
    if (bus.p0_req && bus.p1_req) grant_c = ~last_grant;
    else if (bus.p1_req)          grant_c = 1'b1;
  end

  // Command FSM; all strobes, acks and rvalids are registered one-cycle pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      cmd         <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      rwait_first <= 1'b0;
      mem_we      <= 1'b0;
      mem_re      <= 1'b0;
      p0_ack      <= 1'b0;
      p1_ack      <= 1'b0;
      p0_rvalid   <= 1'b0;
      p1_rvalid   <= 1'b0;
      p0_rdata    <= '0;
      p1_rdata    <= '0;
    end else begin
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      p0_rvalid <= 1'b0;
      p1_rvalid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.mem_ready && (bus.p0_req || bus.p1_req)) begin
            owner  <= grant_c;
            cmd    <= win_cmd_c;
            mem_we <= win_cmd_c.wr;
            mem_re <= ~win_cmd_c.wr;
            p0_ack <= ~grant_c;
            p1_ack <= grant_c;
            state  <= ISSUE;
          end
        end
        ISSUE: begin
          last_grant  <= owner;
          rwait_first <= 1'b1;
          state       <= cmd.wr ? IDLE : RWAIT;
        end
        RWAIT: begin
          // mem_ready may still reflect the pre-command state on the first cycle
          rwait_first <= 1'b0;
          if (!rwait_first && bus.mem_ready) begin
            if (owner) begin
              p1_rdata  <= bus.mem_dout;
              p1_rvalid <= 1'b1;
            end else begin
              p0_rdata  <= bus.mem_dout;
              p0_rvalid <= 1'b1;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_addr  = cmd.addr;
  assign bus.mem_din   = cmd.wdata;
  assign bus.mem_mask  = cmd.mask;
  assign bus.mem_we    = mem_we;
  assign bus.mem_re    = mem_re;
  assign bus.p0_ack    = p0_ack;
  assign bus.p1_ack    = p1_ack;
  assign bus.p0_rvalid = p0_rvalid;
  assign bus.p1_rvalid = p1_rvalid;
  assign bus.p0_rdata  = p0_rdata;
  assign bus.p1_rdata  = p1_rdata;

endmodule

// File: tb/tb_sp_dram_arbiter.sv
// Directed bench for sp_dram_arbiter with a small read-latency memory model.
`timescale 1ns/1ps
module tb_sp_dram_arbiter;

  logic clk;
  logic rst_n;

  sp_dram_arbiter_if #(.ADDR_WIDTH(26), .DATA_WIDTH(128), .MASK_WIDTH(16)) bus ();

  sp_dram_arbiter #(.ADDR_WIDTH(26), .DATA_WIDTH(128), .MASK_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory model: after each read strobe, mem_ready drops for 5 cycles, then data appears.
  logic         model_ready = 1'b1;
  logic         ready_en    = 1'b1;
  logic [127:0] model_dout  = '0;
  logic [127:0] mem_rdata   = '0;
  int           busy        = 0;

  assign bus.mem_ready = model_ready & ready_en;
  assign bus.mem_dout  = model_dout;

  always @(negedge clk) begin
    if (bus.mem_re) begin
      busy        = 5;
      model_ready = 1'b0;
    end else if (busy > 0) begin
      busy = busy - 1;
      if (busy == 0) begin
        model_ready = 1'b1;
        model_dout  = mem_rdata;
      end
    end
  end

  // Protocol monitor: strobe exclusivity, spacing, single outstanding read, event counts.
  logic prev_strobe = 1'b0;
  int   outstanding = 0;
  int   strobe_cnt  = 0;
  int   p1_ack_cnt  = 0;
  int   rv0_cnt     = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      outstanding = 0;
    end else begin
      if (bus.mem_we || bus.mem_re) begin
        check("we_re_excl", 128'(bus.mem_we & bus.mem_re), 128'(0));
        check("strobe_gap", 128'(prev_strobe), 128'(0));
        strobe_cnt++;
      end
      if (bus.mem_re) begin
        check("one_outstanding", 128'(outstanding), 128'(0));
        outstanding++;
      end
      if ((bus.p0_rvalid || bus.p1_rvalid) && outstanding > 0) outstanding--;
      if (bus.p1_ack) p1_ack_cnt++;
      if (bus.p0_rvalid) rv0_cnt++;
    end
    prev_strobe = bus.mem_we | bus.mem_re;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_p0(input logic req, input logic wr, input logic [25:0] addr,
                        input logic [127:0] wdata, input logic [15:0] mask);
    bus.p0_req = req; bus.p0_wr = wr; bus.p0_addr = addr;
    bus.p0_wdata = wdata; bus.p0_mask = mask;
  endtask

  task automatic set_p1(input logic req, input logic wr, input logic [25:0] addr,
                        input logic [127:0] wdata, input logic [15:0] mask);
    bus.p1_req = req; bus.p1_wr = wr; bus.p1_addr = addr;
    bus.p1_wdata = wdata; bus.p1_mask = mask;
  endtask

  // Ticks until the chosen port's rvalid is seen; n = ticks taken, bounded by max.
  task automatic wait_rv(input bit port, input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if ((port ? bus.p1_rvalid : bus.p0_rvalid) === 1'b1) begin
        n = i;
        break;
      end
    end
    if (n == 0) check("rvalid_timeout", 128'(0), 128'(1));
  endtask

  int           n;
  int           snap_a;
  int           snap_b;
  logic [127:0] a5;
  bit           grants[4];
  int           ng;

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    a5    = {16{8'hA5}};
    set_p0(1'b0, 1'b0, '0, '0, '0);
    set_p1(1'b0, 1'b0, '0, '0, '0);

    // Reset state
    tick();
    tick();
    check("rst_mem_we",   128'(bus.mem_we),    128'(0));
    check("rst_mem_re",   128'(bus.mem_re),    128'(0));
    check("rst_p0_ack",   128'(bus.p0_ack),    128'(0));
    check("rst_p1_ack",   128'(bus.p1_ack),    128'(0));
    check("rst_p0_rv",    128'(bus.p0_rvalid), 128'(0));
    check("rst_p1_rv",    128'(bus.p1_rvalid), 128'(0));
    check("rst_p0_rdata", bus.p0_rdata,        128'(0));
    check("rst_p1_rdata", bus.p1_rdata,        128'(0));
    check("rst_mem_addr", 128'(bus.mem_addr),  128'(0));
    check("rst_mem_din",  bus.mem_din,         128'(0));
    check("rst_mem_mask", 128'(bus.mem_mask),  128'(0));
    rst_n = 1'b1;
    tick();

    // Single write from p0
    set_p0(1'b1, 1'b1, 26'h123, a5, 16'hFFFF);
    tick();
    check("wr_mem_we",   128'(bus.mem_we),   128'(1));
    check("wr_mem_re",   128'(bus.mem_re),   128'(0));
    check("wr_mem_addr", 128'(bus.mem_addr), 128'(26'h123));
    check("wr_mem_din",  bus.mem_din,        a5);
    check("wr_mem_mask", 128'(bus.mem_mask), 128'(16'hFFFF));
    check("wr_p0_ack",   128'(bus.p0_ack),   128'(1));
    check("wr_p1_ack",   128'(bus.p1_ack),   128'(0));
    bus.p0_req = 1'b0;
    tick();
    check("wr_done_we",  128'(bus.mem_we),   128'(0));
    check("wr_done_ack", 128'(bus.p0_ack),   128'(0));
    tick();
    check("wr_no_reissue", 128'(bus.mem_we | bus.mem_re), 128'(0));

    // Single read from p1 with 5-cycle memory latency
    mem_rdata = 128'h0000_0000_0000_0000_0000_0000_DEAD_BEEF;
    snap_a = rv0_cnt;
    set_p1(1'b1, 1'b0, 26'h40, '0, '0);
    tick();
    check("rd_mem_re",   128'(bus.mem_re),   128'(1));
    check("rd_mem_we",   128'(bus.mem_we),   128'(0));
    check("rd_mem_addr", 128'(bus.mem_addr), 128'(26'h40));
    check("rd_p1_ack",   128'(bus.p1_ack),   128'(1));
    bus.p1_req = 1'b0;
    wait_rv(1'b1, 20, n);
    check("rd_latency",  128'(n),            128'(6));
    check("rd_p1_rdata", bus.p1_rdata,       128'hDEAD_BEEF);
    check("rd_p0_rdata", bus.p0_rdata,       128'(0));
    tick();
    check("rd_rv_pulse", 128'(bus.p1_rvalid), 128'(0));
    check("rd_p0_rv_cnt", 128'(rv0_cnt - snap_a), 128'(0));

    // Stall: mem_ready low holds off the grant
    ready_en = 1'b0;
    set_p0(1'b1, 1'b1, 26'h55, 128'h1, 16'h0001);
    snap_a = strobe_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_no_ack", 128'(bus.p0_ack), 128'(0));
    end
    check("stall_no_strobe", 128'(strobe_cnt - snap_a), 128'(0));
    ready_en = 1'b1;
    tick();
    check("stall_ack",    128'(bus.p0_ack), 128'(1));
    check("stall_strobe", 128'(bus.mem_we), 128'(1));
    bus.p0_req = 1'b0;
    tick();

    // Contention from reset: both ports read continuously
    rst_n = 1'b0;
    set_p0(1'b1, 1'b0, 26'h10, '0, '0);
    set_p1(1'b1, 1'b0, 26'h20, '0, '0);
    tick();
    rst_n = 1'b1;
    ng = 0;
    for (int i = 0; i < 300 && ng < 4; i++) begin
      tick();
      if (bus.p0_ack || bus.p1_ack) begin
        check("cont_single_ack", 128'(bus.p0_ack & bus.p1_ack), 128'(0));
        grants[ng] = bus.p1_ack;
        ng++;
        if (ng == 4) begin
          bus.p0_req = 1'b0;
          bus.p1_req = 1'b0;
        end
      end
    end
    check("cont_grants", 128'(ng), 128'(4));
    check("cont_g0", 128'(grants[0]), 128'(0));
    check("cont_g1", 128'(grants[1]), 128'(1));
    check("cont_g2", 128'(grants[2]), 128'(0));
    check("cont_g3", 128'(grants[3]), 128'(1));
    wait_rv(1'b1, 20, n);
    tick();

    // Reset during RWAIT abandons the read and restores port-0 priority
    mem_rdata = 128'h1234;
    set_p0(1'b1, 1'b0, 26'h77, '0, '0);
    tick();
    check("rr_p0_ack", 128'(bus.p0_ack), 128'(1));
    bus.p0_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("rr_p0_rdata", bus.p0_rdata, 128'(0));
    check("rr_p1_rdata", bus.p1_rdata, 128'(0));
    snap_a = rv0_cnt;
    for (int i = 0; i < 8; i++) tick();
    check("rr_no_rvalid", 128'(rv0_cnt - snap_a), 128'(0));
    check("rr_rdata_kept", bus.p0_rdata, 128'(0));
    set_p0(1'b1, 1'b1, 26'h1, 128'h11, 16'h00FF);
    set_p1(1'b1, 1'b1, 26'h2, 128'h22, 16'hFF00);
    tick();
    check("rr_next_p0", 128'(bus.p0_ack), 128'(1));
    check("rr_next_p1", 128'(bus.p1_ack), 128'(0));
    bus.p0_req = 1'b0;
    tick();
    tick();
    check("rr_then_p1", 128'(bus.p1_ack), 128'(1));
    bus.p1_req = 1'b0;
    tick();

    // Cancel: p1_req pulsed for one cycle while p0's read is in RWAIT
    mem_rdata = 128'hCAFE;
    set_p0(1'b1, 1'b0, 26'h88, '0, '0);
    tick();
    check("cx_p0_ack", 128'(bus.p0_ack), 128'(1));
    bus.p0_req = 1'b0;
    snap_a = strobe_cnt;
    snap_b = p1_ack_cnt;
    tick();
    set_p1(1'b1, 1'b0, 26'h99, '0, '0);
    tick();
    bus.p1_req = 1'b0;
    wait_rv(1'b0, 20, n);
    check("cx_p0_rdata", bus.p0_rdata, 128'hCAFE);
    for (int i = 0; i < 5; i++) tick();
    check("cx_strobes", 128'(strobe_cnt - snap_a), 128'(1));
    check("cx_no_p1_ack", 128'(p1_ack_cnt - snap_b), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
